// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and frame-aligned value commit.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses segments of leading zero digits 3..1.
module seg7_scan_driver #(
   parameter logic [23:0] SCAN_DIV     = 24'd10_000,
   parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   output logic [6:0]  segments,
   output logic        dp,
   output logic [3:0]  digit_en,
   output logic        frame_done
);

   typedef enum logic {BLANK, SHOW} state_t;

   localparam logic [23:0] BLANK_W   = {16'd0, BLANK_CYCLES};
   localparam logic [23:0] SLOT_LAST = SCAN_DIV - 24'd1;
   localparam state_t      STATE_RST = (BLANK_CYCLES != 8'd0) ? BLANK : SHOW;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   logic [19:0] pending_q, pending_d;
   logic        pending_valid_q, pending_valid_d;
   logic [19:0] display_q, display_d;
   logic [1:0]  slot_q, slot_d;
   logic [23:0] cnt_q, cnt_d;
   state_t      state_q, state_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [3:0]  en_q, en_d;
   logic        fd_q, fd_d;

   logic        boundary;
   logic [3:0]  cur_digit;
   logic [3:0]  cur_dps;
`ifdef LEADING_ZERO_BLANK_EN
   logic        lead_zero;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         display_q       <= '0;
         slot_q          <= '0;
         cnt_q           <= '0;
         state_q         <= STATE_RST;
         seg_q           <= '0;
         dp_q            <= 1'b0;
         en_q            <= '0;
         fd_q            <= 1'b0;
      end else begin
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         display_q       <= display_d;
         slot_q          <= slot_d;
         cnt_q           <= cnt_d;
         state_q         <= state_d;
         seg_q           <= seg_d;
         dp_q            <= dp_d;
         en_q            <= en_d;
         fd_q            <= fd_d;
      end
   end

   always_comb begin
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      display_d       = display_q;
      slot_d          = slot_q;
      cnt_d           = cnt_q + 24'd1;
      seg_d           = '0;
      dp_d            = 1'b0;
      en_d            = '0;
      boundary        = (cnt_q == SLOT_LAST) && (slot_q == 2'd3);
      fd_d            = boundary;
      cur_digit       = display_q[{slot_q, 2'b00} +: 4];
      cur_dps         = display_q[19:16];

      if (cnt_q == SLOT_LAST) begin
         cnt_d  = '0;
         slot_d = slot_q + 2'd1;
      end
      // state tracks the cnt value it will be paired with next cycle
      state_d = (cnt_d < BLANK_W) ? BLANK : SHOW;

      if (load) begin
         pending_d       = {dp_in, digits_in};
         pending_valid_d = 1'b1;
      end

      // a load coinciding with the boundary bypasses pending so it is not delayed a frame
      if (boundary) begin
         if (load) begin
            display_d = {dp_in, digits_in};
         end else if (pending_valid_q) begin
            display_d = pending_q;
         end
         pending_valid_d = 1'b0;
      end

`ifdef LEADING_ZERO_BLANK_EN
      case (slot_q)
         2'd3:    lead_zero = (display_q[15:12] == 4'd0);
         2'd2:    lead_zero = (display_q[15:8] == 8'd0);
         2'd1:    lead_zero = (display_q[15:4] == 12'd0);
         default: lead_zero = 1'b0;
      endcase
`endif

      if (state_q == SHOW) begin
         en_d  = 4'b0001 << slot_q;
         seg_d = hex_decode(cur_digit);
         dp_d  = cur_dps[slot_q];
`ifdef LEADING_ZERO_BLANK_EN
         if (lead_zero) begin
            seg_d = '0;
         end
`endif
      end
   end

   assign segments   = seg_q;
   assign dp         = dp_q;
   assign digit_en   = en_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected outputs come from a cycle-arithmetic model of the scan
// and a log of loads; honours LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_driver;

   localparam int unsigned S  = 8;
   localparam int unsigned B  = 2;
   localparam int unsigned FR = 4 * S;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  digit_en;
   logic        frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .SCAN_DIV    (24'd8),
      .BLANK_CYCLES(8'd2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .segments  (segments),
      .dp        (dp),
      .digit_en  (digit_en),
      .frame_done(frame_done)
   );

   typedef struct {
      int unsigned tag;
      logic [6:0]  seg;
      logic        dp;
      logic [3:0]  en;
      logic        fd;
   } exp_t;

   typedef struct {
      int unsigned idx;
      logic [19:0] v;
   } ld_t;

   exp_t sb[$];
   ld_t  loads[$];

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int unsigned tcyc = 0;
   int unsigned ci   = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   string       phase = "reset";
   exp_t        mon_e;

   // Output seen one cycle after cycle c (counted from reset release).
   function automatic exp_t model(input int unsigned c, input int unsigned tag);
      exp_t        e;
      int unsigned pos, slot, f;
      logic [19:0] val;
      logic [15:0] dv;
      pos  = c % S;
      slot = (c / S) % 4;
      f    = c / FR;
      val  = '0;
      foreach (loads[j]) if (loads[j].idx < f * FR) val = loads[j].v;
      e.tag = tag;
      e.seg = '0;
      e.dp  = 1'b0;
      e.en  = '0;
      e.fd  = ((c % FR) == FR - 1);
      if (pos >= B) begin
         dv    = val[15:0] >> (4 * slot);
         e.en  = 4'(1 << slot);
         e.seg = seg_tab[dv[3:0]];
         e.dp  = val[16 + slot];
`ifdef LEADING_ZERO_BLANK_EN
         if (slot > 0 && dv == 16'd0) e.seg = '0;
`endif
      end
      return e;
   endfunction

   task automatic reset_cycle();
      exp_t e;
      reset     = 1'b1;
      load      = 1'($urandom);
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      e.tag = tcyc + 1;
      e.seg = '0;
      e.dp  = 1'b0;
      e.en  = '0;
      e.fd  = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      tcyc++;
      load = 1'b0;
      ci   = 0;
      loads.delete();
   endtask

   task automatic run_cycle(input logic ld, input logic [15:0] d, input logic [3:0] p);
      ld_t l;
      reset     = 1'b0;
      load      = ld;
      digits_in = d;
      dp_in     = p;
      if (ld) begin
         l.idx = ci;
         l.v   = {p, d};
         loads.push_back(l);
      end
      sb.push_back(model(ci, tcyc + 1));
      @(posedge clk);
      #1;
      tcyc++;
      ci++;
      load = 1'b0;
   endtask

   task automatic idle();
      run_cycle(1'b0, 16'($urandom), 4'($urandom));
   endtask

   task automatic idle_until(input int unsigned m);
      while ((ci % FR) != m) idle();
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].tag < tcyc) begin
         n_checks++;
         $display("FAIL %s missed sample tag=%0d now=%0d", phase, sb[0].tag, tcyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].tag == tcyc) begin
         mon_e = sb.pop_front();
         n_checks++;
         if (segments === mon_e.seg && dp === mon_e.dp && digit_en === mon_e.en &&
             frame_done === mon_e.fd) begin
            n_pass++;
         end else begin
            $display("FAIL %s cyc=%0d got seg=%b dp=%b en=%b fd=%b exp seg=%b dp=%b en=%b fd=%b",
                     phase, tcyc, segments, dp, digit_en, frame_done,
                     mon_e.seg, mon_e.dp, mon_e.en, mon_e.fd);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;

      phase = "reset";
      repeat (3) reset_cycle();

      phase = "idle";
      repeat (3 * FR) idle();

      phase = "load1234";
      idle_until(13);
      run_cycle(1'b1, 16'h1234, 4'b0001);
      repeat (2 * FR) idle();

      phase = "last_wins";
      idle_until(5);
      run_cycle(1'b1, 16'hAAAA, 4'hF);
      idle_until(20);
      run_cycle(1'b1, 16'h5678, 4'h0);
      repeat (2 * FR) idle();

      phase = "bypass";
      idle_until(FR - 1);
      run_cycle(1'b1, 16'h00C0, 4'b0100);
      repeat (2 * FR) idle();

      phase = "lead_zero";
      idle_until(3);
      run_cycle(1'b1, 16'h0070, 4'b0000);
      repeat (2 * FR) idle();

      phase = "reset_mid";
      idle_until(2 * S + 4);
      reset_cycle();
      reset_cycle();
      repeat (FR + 4) idle();

      phase = "no_blank_zero";
      idle_until(0);
      run_cycle(1'b1, 16'h0000, 4'b1010);
      repeat (2 * FR) idle();

      phase = "random";
      repeat (1500) begin
         run_cycle(($urandom % 12) == 0, 16'($urandom), 4'($urandom));
      end

      phase = "drain";
      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain leftover=%0d required=0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
